// File: rtl/lift_pkg.sv
// lift_pkg: shared floor widths, direction codes and scheduler state encoding
package lift_pkg;
    localparam int N_FLOORS = 16;
    localparam int FLOOR_W = 4;
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    // state codes equal the dir codes so dir is the state register itself
    typedef enum logic [1:0] {
        IDLE = DIR_IDLE,
        UP = DIR_UP,
        DOWN = DIR_DOWN
    } state_t;
endpackage

// File: rtl/lift_call_sched_if.sv
// lift_call_sched_if: switch/tick inputs and scheduled-target outputs of lift_call_sched
interface lift_call_sched_if;
    import lift_pkg::*;
    logic sample_tick;
    logic [N_FLOORS-1:0] sw;
    logic [FLOOR_W-1:0] cur_floor;
    logic door_open;
    logic [N_FLOORS-1:0] pending;
    logic [FLOOR_W-1:0] target_floor;
    logic target_valid;
    logic [1:0] dir;
    modport master (
        output sample_tick, sw, cur_floor, door_open,
        input pending, target_floor, target_valid, dir
    );
    modport slave (
        input sample_tick, sw, cur_floor, door_open,
        output pending, target_floor, target_valid, dir
    );
endinterface

// File: rtl/lift_sw_debounce.sv
// lift_sw_debounce: single switch debouncer with stable level and rise pulse
module lift_sw_debounce #(
    parameter int DB_SAMPLES = 3
) (
    input logic clk_100MHz,
    input logic rst_n,
    input logic sample_tick,
    input logic sw,
    output logic stable,
    output logic rise
);
    logic [DB_SAMPLES-1:0] hist_q, hist_d;
    logic stable_q, stable_d;
    always_comb begin
        hist_d = sample_tick ? {hist_q[DB_SAMPLES-2:0], sw} : hist_q;
        stable_d = &hist_d ? 1'b1 : ~|hist_d ? 1'b0 : stable_q;
    end
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            stable_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            stable_q <= stable_d;
        end
    end
    // pulse during the tick cycle that completes a run of highs
    assign rise = stable_d & ~stable_q;
    assign stable = stable_q;
endmodule

// File: rtl/lift_call_sched.sv
// lift_call_sched: debounced call latching and SCAN target scheduling for the lift FSM
module lift_call_sched
    import lift_pkg::*;
#(
    parameter int DB_SAMPLES = 3
) (
    input logic clk_100MHz,
    input logic rst_n,
    lift_call_sched_if.slave bus
);
    logic [N_FLOORS-1:0] rise, level_unused;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [N_FLOORS-1:0] at_mask, below_mask, up_set, dn_set;
    logic [FLOOR_W-1:0] target_q, target_d, lo, hi;
    logic valid_q, valid_d, here, above, below;
    state_t state_q, state_d;
    for (genvar g = 0; g < N_FLOORS; g++) begin : g_db
        lift_sw_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db (
            .clk_100MHz(clk_100MHz),
            .rst_n(rst_n),
            .sample_tick(bus.sample_tick),
            .sw(bus.sw[g]),
            .stable(level_unused[g]),
            .rise(rise[g])
        );
    end
    always_comb begin
        at_mask = N_FLOORS'(1) << bus.cur_floor;
        below_mask = at_mask - N_FLOORS'(1);
        up_set = pending_q & ~below_mask;
        dn_set = pending_q & (below_mask | at_mask);
        here = |(pending_q & at_mask);
        above = |(up_set & ~at_mask);
        below = |(pending_q & below_mask);
        // clear wins over a same-cycle set on the door floor
        pending_d = (pending_q | rise) & ~(bus.door_open ? at_mask : '0);
        lo = '0;
        hi = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--)
            if (up_set[i]) lo = FLOOR_W'(i);
        for (int i = 0; i < N_FLOORS; i++)
            if (dn_set[i]) hi = FLOOR_W'(i);
        state_d = state_q == UP ? ((above || here) ? UP : below ? DOWN : IDLE)
                : state_q == DOWN ? ((below || here) ? DOWN : above ? UP : IDLE)
                : (above ? UP : below ? DOWN : IDLE);
        target_d = state_d == UP ? lo : state_d == DOWN ? hi : here ? bus.cur_floor : target_q;
        valid_d = (state_d != IDLE) || here;
    end
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            target_q <= '0;
            valid_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            pending_q <= pending_d;
            target_q <= target_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end
    assign bus.pending = pending_q;
    assign bus.target_floor = target_q;
    assign bus.target_valid = valid_q;
    assign bus.dir = state_q;
endmodule
